// File: rtl/snd_bus_arb_if.sv
// Signal bundle between the host/GS port decoders, the sound-chip bus pads and snd_bus_arb.
interface snd_bus_arb_if;
  logic       h_req;
  logic       h_wr;
  logic [1:0] h_chip;
  logic       h_a0;
  logic [7:0] h_wdata;
  logic       h_ack;
  logic [7:0] h_rdata;

  logic       g_req;
  logic       g_wr;
  logic [1:0] g_chip;
  logic       g_a0;
  logic [7:0] g_wdata;
  logic       g_ack;
  logic [7:0] g_rdata;

  logic [7:0] bus_din;
  logic [7:0] bus_dout;
  logic       bus_oe;
  logic       bus_a0;
  logic       n_ard;
  logic       n_awr;
  logic       n_ym1_cs;
  logic       n_ym2_cs;
  logic       n_saa_cs;
  logic       busy;
  logic       owner;

  modport slave (
    input  h_req, h_wr, h_chip, h_a0, h_wdata,
    input  g_req, g_wr, g_chip, g_a0, g_wdata,
    input  bus_din,
    output h_ack, h_rdata, g_ack, g_rdata,
    output bus_dout, bus_oe, bus_a0, n_ard, n_awr,
    output n_ym1_cs, n_ym2_cs, n_saa_cs, busy, owner
  );

  modport master (
    output h_req, h_wr, h_chip, h_a0, h_wdata,
    output g_req, g_wr, g_chip, g_a0, g_wdata,
    output bus_din,
    input  h_ack, h_rdata, g_ack, g_rdata,
    input  bus_dout, bus_oe, bus_a0, n_ard, n_awr,
    input  n_ym1_cs, n_ym2_cs, n_saa_cs, busy, owner
  );
endinterface

// File: rtl/snd_bus_arb.sv
// Sound-chip bus arbiter: serializes host and GS Z80 accesses onto the shared AY/YM2203/SAA1099 bus
// as fixed setup/strobe/hold cycles, returning read data and a one-cycle acknowledge.
module snd_bus_arb #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 6,
  parameter int unsigned HOLD_CYC   = 1
) (
  input logic          clk32,
  input logic          rst_n,
  snd_bus_arb_if.slave bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 8;
  localparam logic [1:0]        CHIP_NONE  = 2'd3;
  localparam logic [DATA_W-1:0] RDATA_IDLE = 8'hFF;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              lat_wr, lat_wr_n;
  logic              lat_a0, lat_a0_n;
  logic [1:0]        lat_chip, lat_chip_n;
  logic [DATA_W-1:0] lat_wdata, lat_wdata_n;
  logic              owner_q, owner_n;
  logic              busy_q, busy_n;
  logic              h_ack_q, h_ack_n;
  logic              g_ack_q, g_ack_n;
  logic [DATA_W-1:0] h_rdata_q, h_rdata_n;
  logic [DATA_W-1:0] g_rdata_q, g_rdata_n;
  logic [DATA_W-1:0] dout_q, dout_n;
  logic              oe_q, oe_n;
  logic              a0_q, a0_n;
  logic              ard_q, ard_n;
  logic              awr_q, awr_n;
  logic [2:0]        cs_q, cs_n;      // {saa, ym2, ym1}, active low
  logic              mask_h, mask_g;  // requester acked last cycle
  logic              elig_h, elig_g, pick_g, active, strobe;
  logic [DATA_W-1:0] rd_val;

  // Next state, latched request and next registered outputs
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    lat_wr_n    = lat_wr;
    lat_a0_n    = lat_a0;
    lat_chip_n  = lat_chip;
    lat_wdata_n = lat_wdata;
    owner_n     = owner_q;
    h_rdata_n   = h_rdata_q;
    g_rdata_n   = g_rdata_q;
    elig_h      = bus.h_req & ~mask_h;
    elig_g      = bus.g_req & ~mask_g;
    pick_g      = elig_g & (~elig_h | ~owner_q);
    rd_val      = (lat_chip == CHIP_NONE) ? RDATA_IDLE : bus.bus_din;

    case (state)
      IDLE: begin
        if (elig_h | elig_g) begin
          state_n     = SETUP;
          cnt_n       = CNT_W'(SETUP_CYC - 1);
          owner_n     = pick_g;
          lat_wr_n    = pick_g ? bus.g_wr    : bus.h_wr;
          lat_a0_n    = pick_g ? bus.g_a0    : bus.h_a0;
          lat_chip_n  = pick_g ? bus.g_chip  : bus.h_chip;
          lat_wdata_n = pick_g ? bus.g_wdata : bus.h_wdata;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = STROBE;
          cnt_n   = CNT_W'(STROBE_CYC - 1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          state_n = HOLD;
          cnt_n   = CNT_W'(HOLD_CYC - 1);
          if (!lat_wr) begin
            if (owner_q) g_rdata_n = rd_val;
            else         h_rdata_n = rd_val;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      default: state_n = IDLE;
    endcase

    // Outputs are a function of the state being entered, so they line up with it after the edge
    active  = (state_n != IDLE);
    strobe  = (state_n == STROBE);
    busy_n  = active;
    h_ack_n = (state_n == HOLD) && (cnt_n == '0) && !owner_n;
    g_ack_n = (state_n == HOLD) && (cnt_n == '0) &&  owner_n;
    oe_n    = active & lat_wr_n;
    dout_n  = (active & lat_wr_n) ? lat_wdata_n : dout_q;
    a0_n    = active ? lat_a0_n : a0_q;
    awr_n   = ~(strobe &  lat_wr_n);
    ard_n   = ~(strobe & ~lat_wr_n);
    cs_n    = 3'b111;
    if (active) begin
      case (lat_chip_n)
        2'd0:    cs_n = 3'b110;
        2'd1:    cs_n = 3'b101;
        2'd2:    cs_n = 3'b011;
        default: cs_n = 3'b111;
      endcase
    end
  end

  always_ff @(posedge clk32) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_wr    <= 1'b0;
      lat_a0    <= 1'b0;
      lat_chip  <= CHIP_NONE;
      lat_wdata <= '0;
      owner_q   <= 1'b1;
      busy_q    <= 1'b0;
      h_ack_q   <= 1'b0;
      g_ack_q   <= 1'b0;
      h_rdata_q <= RDATA_IDLE;
      g_rdata_q <= RDATA_IDLE;
      dout_q    <= '0;
      oe_q      <= 1'b0;
      a0_q      <= 1'b0;
      ard_q     <= 1'b1;
      awr_q     <= 1'b1;
      cs_q      <= 3'b111;
      mask_h    <= 1'b0;
      mask_g    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      lat_wr    <= lat_wr_n;
      lat_a0    <= lat_a0_n;
      lat_chip  <= lat_chip_n;
      lat_wdata <= lat_wdata_n;
      owner_q   <= owner_n;
      busy_q    <= busy_n;
      h_ack_q   <= h_ack_n;
      g_ack_q   <= g_ack_n;
      h_rdata_q <= h_rdata_n;
      g_rdata_q <= g_rdata_n;
      dout_q    <= dout_n;
      oe_q      <= oe_n;
      a0_q      <= a0_n;
      ard_q     <= ard_n;
      awr_q     <= awr_n;
      cs_q      <= cs_n;
      mask_h    <= h_ack_q;
      mask_g    <= g_ack_q;
    end
  end

  assign bus.h_ack    = h_ack_q;
  assign bus.g_ack    = g_ack_q;
  assign bus.h_rdata  = h_rdata_q;
  assign bus.g_rdata  = g_rdata_q;
  assign bus.bus_dout = dout_q;
  assign bus.bus_oe   = oe_q;
  assign bus.bus_a0   = a0_q;
  assign bus.n_ard    = ard_q;
  assign bus.n_awr    = awr_q;
  assign bus.n_ym1_cs = cs_q[0];
  assign bus.n_ym2_cs = cs_q[1];
  assign bus.n_saa_cs = cs_q[2];
  assign bus.busy     = busy_q;
  assign bus.owner    = owner_q;

endmodule

// File: tb/tb_snd_bus_arb.sv
// Randomized bench for snd_bus_arb: two requester agents plus random resets, checked every cycle
// against a transaction-timeline model (grant cycle plus offsets).
module tb_snd_bus_arb;
  localparam int S     = 2;
  localparam int T     = 6;
  localparam int H     = 1;
  localparam int L     = S + T + H;
  localparam int N_CYC = 4000;

  logic clk32 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk32 = ~clk32;

  snd_bus_arb_if bus ();

  snd_bus_arb #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) dut (
    .clk32 (clk32),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: one transaction described by its grant cycle and latched fields
  bit         act;
  int         t0;
  bit         m_own;
  bit         m_wr;
  logic [1:0] m_chip;
  logic [7:0] m_dout;
  logic       m_a0o;
  logic [7:0] m_hrd, m_grd, cap;
  int         ack_cyc;
  bit         ack_who;
  int         k;
  bit         busy_now;
  bit         ackv [2];

  // Requester agents: index 0 = host, 1 = GS
  bit         pend  [2];
  bit         extra [2];
  logic       req   [2];
  logic       wr    [2];
  logic [1:0] chip  [2];
  logic       a0    [2];
  logic [7:0] wd    [2];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic m_reset();
    act     = 1'b0;
    t0      = 0;
    m_own   = 1'b1;
    m_wr    = 1'b0;
    m_chip  = 2'd3;
    m_dout  = 8'h00;
    m_a0o   = 1'b0;
    m_hrd   = 8'hFF;
    m_grd   = 8'hFF;
    cap     = 8'h00;
    ack_cyc = -10;
    ack_who = 1'b0;
  endtask

  task automatic new_fields(input int i);
    wr[i]   = 1'($urandom_range(0, 1));
    chip[i] = 2'($urandom_range(0, 3));
    a0[i]   = 1'($urandom_range(0, 1));
    wd[i]   = 8'($urandom);
  endtask

  task automatic drive();
    bus.h_req   = req[0];
    bus.h_wr    = wr[0];
    bus.h_chip  = chip[0];
    bus.h_a0    = a0[0];
    bus.h_wdata = wd[0];
    bus.g_req   = req[1];
    bus.g_wr    = wr[1];
    bus.g_chip  = chip[1];
    bus.g_a0    = a0[1];
    bus.g_wdata = wd[1];
  endtask

  // Compare this cycle's outputs with the timeline of the transaction in flight
  task automatic check_cycle();
    logic [2:0] exp_cs;
    bit         strb;
    k        = cyc - t0;
    busy_now = act && (k >= 1) && (k <= L);
    if (busy_now && k == L && !m_wr) begin
      if (m_own) m_grd = (m_chip == 2'd3) ? 8'hFF : cap;
      else       m_hrd = (m_chip == 2'd3) ? 8'hFF : cap;
    end
    exp_cs = 3'b111;
    if (busy_now && m_chip != 2'd3) exp_cs[m_chip] = 1'b0;
    strb    = busy_now && (k >= S + 1) && (k <= S + T);
    ackv[0] = busy_now && (k == L) && !m_own;
    ackv[1] = busy_now && (k == L) &&  m_own;

    chk("cs",      16'({bus.n_saa_cs, bus.n_ym2_cs, bus.n_ym1_cs}), 16'(exp_cs));
    chk("n_awr",   16'(bus.n_awr),    16'(!(strb && m_wr)));
    chk("n_ard",   16'(bus.n_ard),    16'(!(strb && !m_wr)));
    chk("bus_oe",  16'(bus.bus_oe),   16'(busy_now && m_wr));
    chk("bus_dout",16'(bus.bus_dout), 16'(m_dout));
    chk("bus_a0",  16'(bus.bus_a0),   16'(m_a0o));
    chk("busy",    16'(bus.busy),     16'(busy_now));
    chk("owner",   16'(bus.owner),    16'(m_own));
    chk("h_ack",   16'(bus.h_ack),    16'(ackv[0]));
    chk("g_ack",   16'(bus.g_ack),    16'(ackv[1]));
    chk("h_rdata", 16'(bus.h_rdata),  16'(m_hrd));
    chk("g_rdata", 16'(bus.g_rdata),  16'(m_grd));

    if (busy_now && k == L) begin
      ack_cyc = cyc;
      ack_who = m_own;
      act     = 1'b0;
    end
  endtask

  // Agents react to the expected acknowledge; occasionally a request is held one cycle too long
  task automatic drive_cycle();
    for (int i = 0; i < 2; i++) begin
      if (ackv[i]) begin
        pend[i] = 1'b0;
        if ($urandom_range(0, 1) == 1) extra[i] = 1'b1;
        else                           req[i]   = 1'b0;
      end else if (extra[i]) begin
        extra[i] = 1'b0;
        req[i]   = 1'b0;
      end else if (pend[i]) begin
        req[i] = 1'b1;
        if ($urandom_range(0, 3) == 0) new_fields(i);
      end else if ((cyc == 2) || (cyc > 2 && $urandom_range(0, 3) == 0)) begin
        pend[i] = 1'b1;
        req[i]  = 1'b1;
        new_fields(i);
      end
    end
    drive();
    bus.bus_din = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
    if (act && !m_own && m_wr && (cyc - t0) > S && (cyc - t0) <= S + T)
      rst_n = ($urandom_range(0, 15) != 0);
    else
      rst_n = ($urandom_range(0, 299) != 0);
  endtask

  // Advance the model with the inputs applied during this cycle
  task automatic model_step();
    bit eh, eg;
    int p;
    if (!rst_n) begin
      m_reset();
    end else begin
      if (busy_now && k == S + T) cap = bus.bus_din;
      if (!busy_now) begin
        eh = req[0] && !(ack_cyc == cyc - 1 && ack_who == 1'b0);
        eg = req[1] && !(ack_cyc == cyc - 1 && ack_who == 1'b1);
        if (eh || eg) begin
          p      = (eg && (!eh || !m_own)) ? 1 : 0;
          act    = 1'b1;
          t0     = cyc;
          m_own  = (p == 1);
          m_wr   = wr[p];
          m_chip = chip[p];
          m_a0o  = a0[p];
          if (wr[p]) m_dout = wd[p];
        end
      end
    end
  endtask

  initial begin
    m_reset();
    for (int i = 0; i < 2; i++) begin
      pend[i]  = 1'b0;
      extra[i] = 1'b0;
      req[i]   = 1'b0;
      wr[i]    = 1'b0;
      chip[i]  = 2'd0;
      a0[i]    = 1'b0;
      wd[i]    = 8'h00;
      ackv[i]  = 1'b0;
    end
    drive();
    bus.bus_din = 8'h00;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk32);
    #1;
    rst_n = 1'b1;
    for (cyc = 0; cyc < N_CYC; cyc++) begin
      check_cycle();
      drive_cycle();
      model_step();
      @(posedge clk32);
      #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
